cigar_bt_walker: RTL and testbench

Traceback stage of the CIGAR extension datapath, directly downstream of the per-PE F-vs-M compare stage. It stores the backtrace byte of every DP cell during matrix fill, then on `start` walks from a given end cell back to the origin. Along the way it decodes the direction flags and emits a run-length CIGAR (op, length) stream over a valid/ready handshake.

---
 rtl/cigar_bt_walker.sv | 192 +++++++++++++++++++
 tb/tb_cigar_bt_walker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cigar_bt_walker.sv
// rtl/cigar_bt_walker.sv - backtrace store and CIGAR run-length traceback walker
module cigar_bt_walker #(
    parameter int QW       = 3,
    parameter int TW       = 3,
    parameter int BT_WIDTH = 8,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bt_we,
    input  logic [QW-1:0]       bt_wi,
    input  logic [TW-1:0]       bt_wj,
    input  logic [BT_WIDTH-1:0] bt_wdata,
    input  logic                start,
    input  logic [QW-1:0]       qi_end,
    input  logic [TW-1:0]       tj_end,
    output logic                cig_valid,
    input  logic                cig_ready,
    output logic [1:0]          cig_op,
    output logic [LEN_W-1:0]    cig_len,
    output logic                cig_last,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int DEPTH = 2 ** (QW + TW);
    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_I = 2'd1;
    localparam logic [1:0] OP_D = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DEC, S_FLUSH, S_FIN, S_ERR} state_t;
    typedef enum logic [1:0] {G_H, G_E, G_F} gap_t;

    state_t state, state_n;
    gap_t g, step_g;

    // Cell coordinates carry one extra MSB so that stepping past 0 reads as -1.
    logic [QW:0]          ci, i_nx;
    logic [TW:0]          cj, j_nx;
    logic [BT_WIDTH-1:0]  mem [0:DEPTH-1];
    logic [BT_WIDTH-1:0]  rdata;
    logic [1:0]           run_op, step_op, edge_op;
    logic [LEN_W-1:0]     run_len, edge_len;
    logic                 bad, has_edge, out_free, load, ld_last, advance, drop;

    assign busy = (state != S_IDLE);

    // Backtrace RAM: writes only while idle, registered read issued in RD.
    always_ff @(posedge clk) begin
        if (bt_we && state == S_IDLE)
            mem[{bt_wi, bt_wj}] <= bt_wdata;
        if (state == S_RD)
            rdata <= mem[{ci[QW-1:0], cj[TW-1:0]}];
    end

    // Decode the fetched byte against the current gap state into one step.
    always_comb begin
        bad     = (&rdata) || (rdata[4] && rdata[5]);
        step_op = OP_M;
        step_g  = G_H;
        i_nx    = ci - (QW+1)'(1);
        j_nx    = cj - (TW+1)'(1);
        if (g == G_F || (g == G_H && rdata[5])) begin
            step_op = OP_D;
            i_nx    = ci;
            step_g  = rdata[6] ? G_F : G_H;
        end else if (g == G_E || (g == G_H && rdata[4])) begin
            step_op = OP_I;
            j_nx    = cj;
            step_g  = rdata[7] ? G_E : G_H;
        end
    end

    // Leftover edge run once exactly one coordinate has gone to -1.
    always_comb begin
        has_edge = ci[QW] ^ cj[TW];
        edge_op  = ci[QW] ? OP_D : OP_I;
        edge_len = ci[QW] ? LEN_W'(cj[TW-1:0]) + LEN_W'(1)
                          : LEN_W'(ci[QW-1:0]) + LEN_W'(1);
    end

    // Walker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state plus run-close / emit decisions; emits stall while the output word is held.
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        ld_last  = 1'b0;
        advance  = 1'b0;
        drop     = 1'b0;
        out_free = !cig_valid || cig_ready;
        case (state)
            S_IDLE: if (start) state_n = S_RD;
            S_RD:   state_n = S_DEC;
            S_DEC: begin
                if (bad) begin
                    drop    = 1'b1;
                    state_n = S_ERR;
                end else if (run_len == '0 || step_op == run_op) begin
                    advance = 1'b1;
                end else if (out_free) begin
                    load    = 1'b1;
                    advance = 1'b1;
                end
                if (advance)
                    state_n = (i_nx[QW] || j_nx[TW]) ? S_FLUSH : S_RD;
            end
            S_FLUSH: begin
                if (has_edge) begin
                    if (edge_op == run_op) begin
                        advance = 1'b1;
                    end else if (out_free) begin
                        load    = 1'b1;
                        advance = 1'b1;
                    end
                end else if (out_free) begin
                    load    = 1'b1;
                    ld_last = 1'b1;
                    state_n = S_FIN;
                end
            end
            S_FIN:   if (cig_valid && cig_ready) state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Walk coordinates, gap state, open run accumulator, done/err flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci      <= '0;
            cj      <= '0;
            g       <= G_H;
            run_op  <= OP_M;
            run_len <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == S_ERR) || (state == S_FIN && cig_valid && cig_ready);
            if (state == S_IDLE && start) begin
                ci      <= {1'b0, qi_end};
                cj      <= {1'b0, tj_end};
                g       <= G_H;
                run_len <= '0;
                err     <= 1'b0;
            end
            if (state == S_ERR)
                err <= 1'b1;
            if (advance && state == S_DEC) begin
                ci <= i_nx;
                cj <= j_nx;
                g  <= step_g;
                if (load || run_len == '0) begin
                    run_op  <= step_op;
                    run_len <= LEN_W'(1);
                end else begin
                    run_len <= run_len + LEN_W'(1);
                end
            end else if (advance) begin
                ci <= '1;
                cj <= '1;
                if (load) begin
                    run_op  <= edge_op;
                    run_len <= edge_len;
                end else begin
                    run_len <= run_len + edge_len;
                end
            end
        end
    end

    // Single-stage output word; reload allowed in the cycle the old word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cig_valid <= 1'b0;
            cig_op    <= '0;
            cig_len   <= '0;
            cig_last  <= 1'b0;
        end else if (load) begin
            cig_valid <= 1'b1;
            cig_op    <= run_op;
            cig_len   <= run_len;
            cig_last  <= ld_last;
        end else if (drop || (cig_valid && cig_ready)) begin
            cig_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cigar_bt_walker.sv
// tb/tb_cigar_bt_walker.sv - directed table-driven bench for cigar_bt_walker
module tb_cigar_bt_walker;
    localparam logic [1:0] M = 2'd0;
    localparam logic [1:0] I = 2'd1;
    localparam logic [1:0] D = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bt_we = 1'b0;
    logic [2:0]  bt_wi = '0;
    logic [2:0]  bt_wj = '0;
    logic [7:0]  bt_wdata = '0;
    logic        start = 1'b0;
    logic [2:0]  qi_end = '0;
    logic [2:0]  tj_end = '0;
    logic        cig_valid;
    logic        cig_ready = 1'b0;
    logic [1:0]  cig_op;
    logic [15:0] cig_len;
    logic        cig_last;
    logic        busy;
    logic        done;
    logic        err;

    cigar_bt_walker #(.QW(3), .TW(3), .BT_WIDTH(8), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bt_we(bt_we), .bt_wi(bt_wi), .bt_wj(bt_wj),
        .bt_wdata(bt_wdata), .start(start), .qi_end(qi_end), .tj_end(tj_end),
        .cig_valid(cig_valid), .cig_ready(cig_ready), .cig_op(cig_op),
        .cig_len(cig_len), .cig_last(cig_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Packed lists: element [0] (rightmost) is the first write / first expected word.
    typedef struct {
        int               nwr;
        logic [3:0][5:0]  waddr;
        logic [3:0][7:0]  wdata;
        logic [2:0]       qi;
        logic [2:0]       tj;
        logic             exp_err;
        int               nexp;
        logic [2:0][1:0]  eop;
        logic [2:0][15:0] elen;
    } vec_t;

    vec_t        tv [9];
    int          total = 0;
    int          bad = 0;
    int          nw;
    logic        w_err;
    logic        w_done;
    logic [1:0]  w_op   [16];
    logic [15:0] w_len  [16];
    logic        w_last [16];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] i, input logic [2:0] j, input logic [7:0] d);
        @(negedge clk);
        bt_we = 1'b1; bt_wi = i; bt_wj = j; bt_wdata = d;
        @(negedge clk);
        bt_we = 1'b0;
    endtask

    task automatic walk(input logic [2:0] qi, input logic [2:0] tj, input int hold, input bit poke);
        int         stall;
        bit         prev_last;
        logic [1:0]  hop;
        logic [15:0] hlen;
        logic        hlast;
        nw = 0; w_err = 1'b0; w_done = 1'b0; stall = 0; prev_last = 1'b0;
        hop = '0; hlen = '0; hlast = 1'b0;
        @(negedge clk);
        start = 1'b1; qi_end = qi; tj_end = tj; cig_ready = (hold == 0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (poke) begin
            bt_we = 1'b1; bt_wi = 3'd0; bt_wj = 3'd0; bt_wdata = 8'hFF;
            start = 1'b1; qi_end = 3'd1; tj_end = 3'd1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                bt_we = 1'b0; start = 1'b0;
            end
            if (prev_last) begin
                chk("done_after_last", done, 1);
                prev_last = 1'b0;
            end
            if (done) begin
                w_done = 1'b1;
                w_err = err;
                chk("busy_low_with_done", busy, 0);
                break;
            end
            if (cig_valid) begin
                if (stall < hold) begin
                    if (stall == 0) begin
                        hop = cig_op; hlen = cig_len; hlast = cig_last;
                    end else begin
                        chk("stall_op_stable", cig_op, hop);
                        chk("stall_len_stable", cig_len, hlen);
                        chk("stall_last_stable", cig_last, hlast);
                    end
                    cig_ready = 1'b0;
                    stall++;
                end else begin
                    cig_ready = 1'b1;
                    if (nw < 16) begin
                        w_op[nw] = cig_op; w_len[nw] = cig_len; w_last[nw] = cig_last;
                    end
                    prev_last = cig_last;
                    nw++;
                    stall = 0;
                end
            end else begin
                cig_ready = (hold == 0);
            end
        end
        chk("walk_reached_done", w_done, 1);
        @(negedge clk);
        chk("done_single_cycle", done, 0);
    endtask

    task automatic check_words(input string name, input int nexp, input logic [2:0][1:0] eop,
                               input logic [2:0][15:0] elen, input logic exp_err);
        chk($sformatf("%s_count", name), nw, nexp);
        chk($sformatf("%s_err", name), w_err, exp_err);
        chk($sformatf("%s_err_sticky", name), err, exp_err);
        for (int k = 0; k < nexp; k++) begin
            chk($sformatf("%s_op%0d", name, k), w_op[k], eop[k]);
            chk($sformatf("%s_len%0d", name, k), w_len[k], elen[k]);
            chk($sformatf("%s_last%0d", name, k), w_last[k], (k == nexp - 1));
        end
    endtask

    task automatic run_vec(input vec_t v, input string name, input int hold);
        for (int k = 0; k < v.nwr; k++)
            wr(v.waddr[k][5:3], v.waddr[k][2:0], v.wdata[k]);
        walk(v.qi, v.tj, hold, 1'b0);
        check_words(name, v.nexp, v.eop, v.elen, v.exp_err);
    endtask

    initial begin
        // deletion: M1, D1, M2
        tv[0] = '{4, {6'o00, 6'o11, 6'o12, 6'o23}, {8'h00, 8'h00, 8'h20, 8'h00},
                  3'd2, 3'd3, 1'b0, 3, {M, D, M}, {16'd2, 16'd1, 16'd1}};
        // gap extension: D2, M2
        tv[1] = '{4, {6'o00, 6'o11, 6'o12, 6'o13}, {8'h00, 8'h00, 8'h00, 8'h60},
                  3'd1, 3'd3, 1'b0, 2, {2'd0, M, D}, {16'd0, 16'd2, 16'd2}};
        // edge flush on i: M2, D3
        tv[2] = '{2, {6'o00, 6'o00, 6'o03, 6'o14}, {8'h00, 8'h00, 8'h00, 8'h00},
                  3'd1, 3'd4, 1'b0, 2, {2'd0, D, M}, {16'd0, 16'd3, 16'd2}};
        // edge flush on j: M2, I3
        tv[3] = '{2, {6'o00, 6'o00, 6'o30, 6'o41}, {8'h00, 8'h00, 8'h00, 8'h00},
                  3'd4, 3'd1, 1'b0, 2, {2'd0, I, M}, {16'd0, 16'd3, 16'd2}};
        // E extension: I2, M1
        tv[4] = '{3, {6'o00, 6'o00, 6'o10, 6'o20}, {8'h00, 8'h00, 8'h00, 8'h90},
                  3'd2, 3'd0, 1'b0, 2, {2'd0, M, I}, {16'd0, 16'd1, 16'd2}};
        // 0xFF at the end cell
        tv[5] = '{1, {6'o00, 6'o00, 6'o00, 6'o33}, {8'h00, 8'h00, 8'h00, 8'hFF},
                  3'd3, 3'd3, 1'b1, 0, {2'd0, 2'd0, 2'd0}, {16'd0, 16'd0, 16'd0}};
        // recovery after error: M4, err cleared
        tv[6] = '{1, {6'o00, 6'o00, 6'o00, 6'o33}, {8'h00, 8'h00, 8'h00, 8'h00},
                  3'd3, 3'd3, 1'b0, 1, {2'd0, 2'd0, M}, {16'd0, 16'd0, 16'd4}};
        // bit4 and bit5 both set
        tv[7] = '{1, {6'o00, 6'o00, 6'o00, 6'o00}, {8'h00, 8'h00, 8'h00, 8'h30},
                  3'd0, 3'd0, 1'b1, 0, {2'd0, 2'd0, 2'd0}, {16'd0, 16'd0, 16'd0}};
        // invalid byte after one step: open run discarded, no words
        tv[8] = '{2, {6'o00, 6'o00, 6'o01, 6'o11}, {8'h00, 8'h00, 8'hFF, 8'h10},
                  3'd1, 3'd1, 1'b1, 0, {2'd0, 2'd0, 2'd0}, {16'd0, 16'd0, 16'd0}};

        repeat (3) @(negedge clk);
        chk("rst_cig_valid", cig_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cig_len", cig_len, 0);
        chk("rst_cig_last", cig_last, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                wr(3'(i), 3'(j), 8'h00);
        walk(3'd3, 3'd3, 0, 1'b0);
        check_words("pure_match", 1, {2'd0, 2'd0, M}, {16'd0, 16'd0, 16'd4}, 1'b0);

        // write and start while busy must both be ignored
        walk(3'd3, 3'd3, 0, 1'b1);
        check_words("busy_ignore", 1, {2'd0, 2'd0, M}, {16'd0, 16'd0, 16'd4}, 1'b0);
        walk(3'd0, 3'd0, 0, 1'b0);
        check_words("dropped_write", 1, {2'd0, 2'd0, M}, {16'd0, 16'd0, 16'd1}, 1'b0);

        for (int k = 0; k < 9; k++)
            run_vec(tv[k], $sformatf("vec%0d", k), 0);

        run_vec(tv[0], "backpressure", 10);

        // reset in the middle of a stalled walk
        @(negedge clk);
        start = 1'b1; qi_end = 3'd2; tj_end = 3'd3; cig_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midwalk_valid_pending", cig_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", cig_valid, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_len", cig_len, 0);
        chk("midreset_op", cig_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("postreset_done", done, 0);
        run_vec(tv[0], "after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
